// File: rtl/uart_tx_queue_if.sv
// Producer-side write port and uart_tx send/busy handshake for uart_tx_queue.
interface uart_tx_queue_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [7:0]    wr_data;
  logic          wr_en;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;
  logic          overflow;
  logic [7:0]    tx_data;
  logic          tx_send;
  logic          tx_busy;

  modport master (
    output wr_data, wr_en, tx_busy,
    input  full, empty, level, overflow, tx_data, tx_send
  );

  modport slave (
    input  wr_data, wr_en, tx_busy,
    output full, empty, level, overflow, tx_data, tx_send
  );
endinterface

// File: rtl/uart_tx_queue.sv
// Byte FIFO drained into uart_tx one byte at a time, paced on tx_busy.
// Define UART_TXQ_OVF_CNT_EN to add the saturating dropped-byte counter (ovf_count/ovf_clr).
module uart_tx_queue #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned BUSY_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef UART_TXQ_OVF_CNT_EN
  input  logic        ovf_clr,
  output logic [15:0] ovf_count,
`endif
  uart_tx_queue_if.slave q_if
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(BUSY_WAIT + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RISE, WAIT_FALL} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    tx_data_q;
  logic          overflow_q;
  logic          full, empty, push, drop, pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = q_if.wr_en && !full;
  assign drop  = q_if.wr_en && full;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty && !q_if.tx_busy) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        state_d = WAIT_RISE;
        timer_d = '0;
      end
      WAIT_RISE: begin
        if (q_if.tx_busy) begin
          state_d = WAIT_FALL;
        end else if (timer_q == TW'(BUSY_WAIT - 1)) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_FALL: begin
        if (!q_if.tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      overflow_q <= drop;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        tx_data_q <= mem_q[rd_ptr_q[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= q_if.wr_data;
  end

  assign q_if.full     = full;
  assign q_if.empty    = empty;
  assign q_if.level    = wr_ptr_q - rd_ptr_q;
  assign q_if.overflow = overflow_q;
  assign q_if.tx_data  = tx_data_q;
  assign q_if.tx_send  = (state_q == SEND);

`ifdef UART_TXQ_OVF_CNT_EN
  logic [15:0] ovf_cnt_q;

  // A clear coinciding with a drop keeps that drop in the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt_q <= '0;
    end else if (ovf_clr) begin
      ovf_cnt_q <= drop ? 16'd1 : 16'd0;
    end else if (drop && (ovf_cnt_q != '1)) begin
      ovf_cnt_q <= ovf_cnt_q + 1'b1;
    end
  end

  assign ovf_count = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue with a behavioural uart_tx busy model.
module tb_uart_tx_queue;
  localparam int unsigned DEPTH     = 16;
  localparam int unsigned BUSY_WAIT = 8;

  logic clk = 1'b0;
  logic rst_n;
`ifdef UART_TXQ_OVF_CNT_EN
  logic        ovf_clr;
  logic [15:0] ovf_count;
`endif

  uart_tx_queue_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_queue #(.DEPTH(DEPTH), .BUSY_WAIT(BUSY_WAIT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef UART_TXQ_OVF_CNT_EN
    .ovf_clr  (ovf_clr),
    .ovf_count(ovf_count),
`endif
    .q_if     (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [7:0] exp_q [$];
  logic [7:0] sent_q [$];
  int send_cyc_q [$];
  int busy_len   = 4;
  bit busy_force = 1'b0;
  bit busy_mute  = 1'b0;
  int busy_cnt   = 0;
  bit prev_send  = 1'b0;
  int dbl_send   = 0;
  int ovf_seen   = 0;

  always @(posedge clk) cyc++;

  // uart_tx stand-in: busy for busy_len cycles starting in the send cycle; also records sends.
  always @(negedge clk) begin
    if (bus.tx_send === 1'b1) begin
      sent_q.push_back(bus.tx_data);
      send_cyc_q.push_back(cyc);
      if (prev_send) dbl_send++;
    end
    prev_send = (bus.tx_send === 1'b1);
    if (bus.overflow === 1'b1) ovf_seen++;
    if (bus.tx_send === 1'b1 && !busy_mute) busy_cnt = busy_len;
    else if (busy_cnt > 0) busy_cnt--;
    bus.tx_busy = busy_force || (busy_cnt != 0);
  end

  task automatic wait_sent(input int n, output bit ok);
    for (int i = 0; i < 3000 && sent_q.size() < n; i++) @(negedge clk);
    ok = (sent_q.size() >= n);
  endtask

  task automatic clear_model();
    exp_q.delete();
    sent_q.delete();
    send_cyc_q.delete();
  endtask

  task automatic test_reset();
    n_tests++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", bus.full); end
    n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
    n_tests++; if (bus.level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", bus.level); end
    n_tests++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
    n_tests++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", bus.tx_data); end
    n_tests++; if (bus.tx_send !== 1'b0) begin n_fail++; $display("FAIL reset_tx_send: got %b expected 0", bus.tx_send); end
  endtask

  task automatic test_basic();
    int c0 = 0;
    bit ok;
    busy_len = 10;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.wr_en = 1'b1;
      bus.wr_data = 8'h41 + 8'(i);
      exp_q.push_back(8'h41 + 8'(i));
      if (i == 0) c0 = cyc;
    end
    @(posedge clk); #1; bus.wr_en = 1'b0;
    wait_sent(3, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL basic_timeout: sent %0d expected 3", sent_q.size()); end
    for (int i = 0; i < sent_q.size() && i < 3; i++) begin
      n_tests++;
      if (sent_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_byte%0d: got %h expected %h", i, sent_q[i], exp_q[i]); end
    end
    if (send_cyc_q.size() >= 2) begin
      n_tests++;
      if (send_cyc_q[0] - c0 != 2) begin n_fail++; $display("FAIL basic_latency: got %0d expected 2", send_cyc_q[0] - c0); end
      n_tests++;
      if (send_cyc_q[1] - send_cyc_q[0] != busy_len + 2) begin
        n_fail++; $display("FAIL basic_spacing: got %0d expected %0d", send_cyc_q[1] - send_cyc_q[0], busy_len + 2);
      end
    end
    repeat (20) @(posedge clk);
    n_tests++; if (sent_q.size() != 3) begin n_fail++; $display("FAIL basic_send_count: got %0d expected 3", sent_q.size()); end
    clear_model();
  endtask

  task automatic test_no_busy();
    bit ok;
    busy_mute = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      bus.wr_en = 1'b1;
      bus.wr_data = 8'($urandom);
      exp_q.push_back(bus.wr_data);
    end
    @(posedge clk); #1; bus.wr_en = 1'b0;
    wait_sent(2, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL nobusy_timeout: sent %0d expected 2", sent_q.size()); end
    for (int i = 0; i < sent_q.size() && i < 2; i++) begin
      n_tests++;
      if (sent_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL nobusy_byte%0d: got %h expected %h", i, sent_q[i], exp_q[i]); end
    end
    if (send_cyc_q.size() >= 2) begin
      n_tests++;
      if (send_cyc_q[1] - send_cyc_q[0] != BUSY_WAIT + 2) begin
        n_fail++; $display("FAIL nobusy_spacing: got %0d expected %0d", send_cyc_q[1] - send_cyc_q[0], BUSY_WAIT + 2);
      end
    end
    busy_mute = 1'b0;
    repeat (20) @(posedge clk);
    clear_model();
  endtask

  task automatic test_overflow();
    int ovf0;
    bit ok;
    busy_force = 1'b1;
    repeat (3) @(posedge clk);
    ovf0 = ovf_seen;
    for (int i = 0; i < DEPTH + 1; i++) begin
      @(posedge clk); #1;
      bus.wr_en = 1'b1;
      bus.wr_data = 8'($urandom);
      if (i < DEPTH) exp_q.push_back(bus.wr_data);
    end
    @(posedge clk); #1; bus.wr_en = 1'b0;
    n_tests++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse: got %b expected 1", bus.overflow); end
    n_tests++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b expected 1", bus.full); end
    n_tests++; if (bus.level !== 5'd16) begin n_fail++; $display("FAIL ovf_level: got %0d expected 16", bus.level); end
    @(posedge clk); #1;
    n_tests++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_pulse_end: got %b expected 0", bus.overflow); end
    @(negedge clk);
    n_tests++; if (ovf_seen - ovf0 != 1) begin n_fail++; $display("FAIL ovf_pulse_count: got %0d expected 1", ovf_seen - ovf0); end
    busy_len = 3;
    busy_force = 1'b0;
    wait_sent(DEPTH, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL ovf_drain_timeout: sent %0d expected %0d", sent_q.size(), DEPTH); end
    for (int i = 0; i < sent_q.size() && i < DEPTH; i++) begin
      n_tests++;
      if (sent_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_byte%0d: got %h expected %h", i, sent_q[i], exp_q[i]); end
    end
    repeat (20) @(posedge clk);
    n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL ovf_empty_after: got %b expected 1", bus.empty); end
    clear_model();
  endtask

  task automatic test_push_pop_same();
    bit ok;
    busy_force = 1'b1;
    busy_len = 2;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.wr_en = 1'b1;
      bus.wr_data = 8'($urandom);
      exp_q.push_back(bus.wr_data);
    end
    @(posedge clk); #1; bus.wr_en = 1'b0;
    n_tests++; if (bus.level !== 5'd5) begin n_fail++; $display("FAIL pp_level_before: got %0d expected 5", bus.level); end
    busy_force = 1'b0;
    @(negedge clk); #1;
    bus.wr_en = 1'b1;
    bus.wr_data = 8'($urandom);
    exp_q.push_back(bus.wr_data);
    @(posedge clk); #1; bus.wr_en = 1'b0;
    n_tests++; if (bus.tx_send !== 1'b1) begin n_fail++; $display("FAIL pp_popped: got %b expected 1", bus.tx_send); end
    n_tests++; if (bus.level !== 5'd5) begin n_fail++; $display("FAIL pp_level_after: got %0d expected 5", bus.level); end
    wait_sent(6, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL pp_timeout: sent %0d expected 6", sent_q.size()); end
    for (int i = 0; i < sent_q.size() && i < 6; i++) begin
      n_tests++;
      if (sent_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL pp_byte%0d: got %h expected %h", i, sent_q[i], exp_q[i]); end
    end
    repeat (20) @(posedge clk);
    n_tests++; if (sent_q.size() != 6) begin n_fail++; $display("FAIL pp_send_count: got %0d expected 6", sent_q.size()); end
    clear_model();
  endtask

`ifdef UART_TXQ_OVF_CNT_EN
  task automatic test_ovf_count();
    bit ok;
    busy_force = 1'b1;
    repeat (3) @(posedge clk);
    @(posedge clk); #1; ovf_clr = 1'b1;
    @(posedge clk); #1; ovf_clr = 1'b0;
    n_tests++; if (ovf_count !== 16'd0) begin n_fail++; $display("FAIL ovfcnt_clear0: got %0d expected 0", ovf_count); end
    for (int i = 0; i < DEPTH + 3; i++) begin
      @(posedge clk); #1;
      bus.wr_en = 1'b1;
      bus.wr_data = 8'($urandom);
      if (i < DEPTH) exp_q.push_back(bus.wr_data);
    end
    @(posedge clk); #1; bus.wr_en = 1'b0;
    n_tests++; if (ovf_count !== 16'd3) begin n_fail++; $display("FAIL ovfcnt_three: got %0d expected 3", ovf_count); end
    ovf_clr = 1'b1;
    bus.wr_en = 1'b1;
    @(posedge clk); #1; ovf_clr = 1'b0; bus.wr_en = 1'b0;
    n_tests++; if (ovf_count !== 16'd1) begin n_fail++; $display("FAIL ovfcnt_clr_drop: got %0d expected 1", ovf_count); end
    ovf_clr = 1'b1;
    @(posedge clk); #1; ovf_clr = 1'b0;
    n_tests++; if (ovf_count !== 16'd0) begin n_fail++; $display("FAIL ovfcnt_clear: got %0d expected 0", ovf_count); end
    busy_force = 1'b0;
    wait_sent(DEPTH, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL ovfcnt_drain_timeout: sent %0d expected %0d", sent_q.size(), DEPTH); end
    for (int i = 0; i < sent_q.size() && i < DEPTH; i++) begin
      n_tests++;
      if (sent_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovfcnt_byte%0d: got %h expected %h", i, sent_q[i], exp_q[i]); end
    end
    repeat (20) @(posedge clk);
    clear_model();
  endtask
`endif

  task automatic test_random();
    bit ok;
    int n;
    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, 10));
      busy_len = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) begin
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        bus.wr_en = 1'b1;
        bus.wr_data = 8'($urandom);
        exp_q.push_back(bus.wr_data);
      end
      @(posedge clk); #1; bus.wr_en = 1'b0;
      wait_sent(n, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL rand%0d_timeout: sent %0d expected %0d", r, sent_q.size(), n); end
      for (int i = 0; i < sent_q.size() && i < n; i++) begin
        n_tests++;
        if (sent_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_byte%0d: got %h expected %h", r, i, sent_q[i], exp_q[i]); end
      end
      repeat (20) @(posedge clk); #1;
      n_tests++; if (bus.level !== 5'd0) begin n_fail++; $display("FAIL rand%0d_level: got %0d expected 0", r, bus.level); end
      n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL rand%0d_empty: got %b expected 1", r, bus.empty); end
      clear_model();
    end
    n_tests++; if (dbl_send != 0) begin n_fail++; $display("FAIL send_pulse_width: got %0d wide pulses expected 0", dbl_send); end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    busy_force = 1'b1;
    busy_len = 30;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus.wr_en = 1'b1;
      bus.wr_data = 8'hA0 + 8'(i + 1);
    end
    @(posedge clk); #1; bus.wr_en = 1'b0;
    busy_force = 1'b0;
    wait_sent(1, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL mid_first_send_timeout: sent %0d expected 1", sent_q.size()); end
    repeat (3) @(negedge clk);
    n_tests++; if (bus.level !== 5'd3) begin n_fail++; $display("FAIL mid_level_before: got %0d expected 3", bus.level); end
    n_tests++; if (bus.tx_data !== 8'hA1) begin n_fail++; $display("FAIL mid_tx_data_before: got %h expected a1", bus.tx_data); end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus.level !== 5'd0) begin n_fail++; $display("FAIL mid_level: got %0d expected 0", bus.level); end
    n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL mid_empty: got %b expected 1", bus.empty); end
    n_tests++; if (bus.tx_send !== 1'b0) begin n_fail++; $display("FAIL mid_tx_send: got %b expected 0", bus.tx_send); end
    n_tests++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL mid_tx_data: got %h expected 00", bus.tx_data); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_model();
    repeat (50) @(posedge clk);
    n_tests++; if (sent_q.size() != 0) begin n_fail++; $display("FAIL mid_discarded: got %0d sends expected 0", sent_q.size()); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
`ifdef UART_TXQ_OVF_CNT_EN
    ovf_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    test_basic();
    test_no_busy();
    test_overflow();
    test_push_pop_same();
`ifdef UART_TXQ_OVF_CNT_EN
    test_ovf_count();
`endif
    test_random();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
